// File: rtl/fetch_queue.sv
// In-order {PC, instruction} buffer between fetch and decode.
// Tags each entry with a fetch-address exception flag and empties in one cycle on redirect.
module fetch_queue #(
   parameter int          DEPTH = 4,
   parameter int          PTR_W = 2,
   parameter logic [31:0] IM_LO = 32'h0000_3000,
   parameter logic [31:0] IM_HI = 32'h0000_6FFC
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_instr,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instr,
   output logic             out_exc,
   input  logic             out_ready,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [31:0]      r_pc_mem    [DEPTH];
   logic [31:0]      r_instr_mem [DEPTH];
   logic             r_exc_mem   [DEPTH];

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic [PTR_W:0]   w_count_next;

   logic             w_push;
   logic             w_pop;
   logic             w_in_exc;

   // Handshakes depend on registered occupancy only, so in_ready never sees out_ready.
   assign in_ready  = (r_count != FULL_CNT);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign w_in_exc  = (in_pc[1:0] != 2'b00) | (in_pc < IM_LO) | (in_pc > IM_HI);

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
         2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Entry storage is never cleared; the pointers and count alone define what is live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_tail]    <= in_pc;
         r_instr_mem[r_tail] <= in_instr;
         r_exc_mem[r_tail]   <= w_in_exc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + PTR_W'(1);
         if (w_pop)  r_head <= r_head + PTR_W'(1);
         r_count <= w_count_next;
      end
   end

   // Gate the head so an empty queue presents a clean bubble (nop at PC 0).
   always_comb begin
      out_pc    = 32'h0;
      out_instr = 32'h0;
      out_exc   = 1'b0;
      if (out_valid) begin
         out_pc    = r_pc_mem[r_head];
         out_instr = r_instr_mem[r_head];
         out_exc   = r_exc_mem[r_head];
      end
   end

   assign count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a random run, checked against a queue-based model.
module tb_fetch_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          exc;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = 32'h0;
   logic [31:0] in_instr = 32'h0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_exc;
   logic        out_ready = 1'b0;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   ent_t mq[$];

   fetch_queue dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_exc   (out_exc),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit addr_exc(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
   endfunction

   // Advance one clock and apply the queue rules to the model.
   task automatic tick();
      bit   do_push, do_pop, clr;
      ent_t e;
      clr     = reset || flush;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      e.pc    = in_pc;
      e.instr = in_instr;
      e.exc   = addr_exc(in_pc);
      @(posedge clk);
      if (clr) mq.delete();
      else begin
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
      #1;
   endtask

   task automatic push_word(input logic [31:0] pc, input logic [31:0] instr);
      in_valid = 1'b1;
      in_pc    = pc;
      in_instr = instr;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic clear_q();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_exc !== 1'b0
          || count !== 3'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b pc=%h instr=%h exc=%b cnt=%0d rdy=%b want 0/0/0/0/0/1",
                  out_valid, out_pc, out_instr, out_exc, count, in_ready);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_single();
      out_ready = 1'b0;
      push_word(32'h3000, 32'h2401_0001);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== 32'h2401_0001 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL single_push: got v=%b pc=%h instr=%h cnt=%0d want 1/3000/24010001/1",
                  out_valid, out_pc, out_instr, count);
      end
      $display("[TB] test_single pc=%h instr=%h", out_pc, out_instr);
      clear_q();
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'h3000 + 32'(4*i), 32'hA000_0000 + 32'(i));
      n_tests++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_state: got cnt=%0d rdy=%b want 4/0", count, in_ready);
      end
      push_word(32'h3010, 32'hDEAD_BEEF);
      n_tests++;
      if (count !== 3'd4 || out_pc !== 32'h3000) begin
         n_fail++;
         $display("FAIL full_reject: got cnt=%0d head=%h want 4/3000", count, out_pc);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (out_pc !== 32'h3000 + 32'(4*i) || out_instr !== 32'hA000_0000 + 32'(i)) begin
            n_fail++;
            $display("FAIL drain_order[%0d]: got pc=%h instr=%h want %h/%h", i, out_pc, out_instr,
                     32'h3000 + 32'(4*i), 32'hA000_0000 + 32'(i));
         end
         $display("[TB] drain pop pc=%h", out_pc);
         tick();
      end
      out_ready = 1'b0;
      n_tests++;
      if (count !== 3'd0 || out_instr !== 32'h0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_empty: got cnt=%0d instr=%h v=%b want 0/0/0", count, out_instr, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] nxt;
      out_ready = 1'b0;
      push_word(32'h3000, 32'h1);
      push_word(32'h3004, 32'h2);
      nxt = 32'h3008;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_pc = nxt; in_instr = nxt ^ 32'h5A5A_0000;
         n_tests++;
         if (out_pc !== 32'h3000 + 32'(4*k)) begin
            n_fail++;
            $display("FAIL stream_order[%0d]: got pc=%h want %h", k, out_pc, 32'h3000 + 32'(4*k));
         end
         tick();
         nxt += 4;
         n_tests++;
         if (count !== 3'd2) begin
            n_fail++;
            $display("FAIL stream_count[%0d]: got %0d want 2", k, count);
         end
         $display("[TB] stream cycle %0d head=%h cnt=%0d", k, out_pc, count);
      end
      clear_q();
   endtask

   task automatic test_flush_full();
      bit seen;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'h3100 + 32'(4*i), 32'(i));
      in_valid = 1'b1; in_pc = 32'h3020; in_instr = 32'h1234_5678; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_full: got cnt=%0d v=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
      end
      seen = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (out_valid === 1'b1 || out_pc === 32'h3020) seen = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL flush_drop: got flushed-cycle word visible=1 want 0");
      end
      $display("[TB] test_flush_full cnt=%0d", count);
   endtask

   task automatic test_exc();
      logic [31:0] pcs [4];
      bit          want [4];
      pcs[0] = 32'h3002; pcs[1] = 32'h2FFC; pcs[2] = 32'h7000; pcs[3] = 32'h6FFC;
      want[0] = 1'b1;    want[1] = 1'b1;    want[2] = 1'b1;    want[3] = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(pcs[i], 32'hC0DE_0000 + 32'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (out_pc !== pcs[i] || out_exc !== want[i] || out_instr !== 32'hC0DE_0000 + 32'(i)) begin
            n_fail++;
            $display("FAIL exc_flag[%0d]: got pc=%h exc=%b instr=%h want %h/%b/%h", i, out_pc, out_exc,
                     out_instr, pcs[i], want[i], 32'hC0DE_0000 + 32'(i));
         end
         $display("[TB] exc pop pc=%h exc=%b", out_pc, out_exc);
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_word(32'h3200 + 32'(4*i), 32'(i));
      in_valid = 1'b1; in_pc = 32'h320C; out_ready = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got cnt=%0d v=%b want 0/0", count, out_valid);
      end
      push_word(32'h3000, 32'h2401_0001);
      n_tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h3000 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL reset_repush: got v=%b pc=%h cnt=%0d want 1/3000/1", out_valid, out_pc, count);
      end
      $display("[TB] test_reset_midstream head=%h", out_pc);
      clear_q();
   endtask

   task automatic test_random();
      logic [31:0] e_pc, e_instr;
      bit          e_exc;
      int          bad;
      bad = 0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 5))
            0:       in_pc = 32'h2FFC + 32'($urandom_range(0, 8));
            1:       in_pc = 32'h6FF8 + 32'($urandom_range(0, 8));
            default: in_pc = 32'h3000 + 32'(4 * $urandom_range(0, 4095));
         endcase
         in_instr = $urandom;
         tick();
         if (mq.size() > 0) begin
            e_pc = mq[0].pc; e_instr = mq[0].instr; e_exc = mq[0].exc;
         end else begin
            e_pc = 32'h0; e_instr = 32'h0; e_exc = 1'b0;
         end
         n_tests++;
         if (count !== 3'(mq.size()) || out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH)
             || out_pc !== e_pc || out_instr !== e_instr || out_exc !== e_exc) begin
            n_fail++;
            bad++;
            $display("FAIL random[%0d]: got cnt=%0d v=%b rdy=%b pc=%h instr=%h exc=%b want %0d/%b/%b/%h/%h/%b",
                     c, count, out_valid, in_ready, out_pc, out_instr, out_exc, mq.size(),
                     mq.size() > 0, mq.size() < DEPTH, e_pc, e_instr, e_exc);
         end
      end
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      $display("[TB] test_random 400 cycles, %0d mismatching", bad);
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_back_to_back();
      test_flush_full();
      test_exc();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
